// File: rtl/femtorv_mem_arbiter.sv
// Two-master round-robin arbiter sharing one FemtoRV32-style strobe/busy memory port.
// One pending slot per master, at most one slave transaction in flight.
module femtorv_mem_arbiter #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [31:0]           m0_wdata,
    input  logic [3:0]            m0_wmask,
    input  logic                  m0_rstrb,
    output logic [31:0]           m0_rdata,
    output logic                  m0_rbusy,
    output logic                  m0_wbusy,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [31:0]           m1_wdata,
    input  logic [3:0]            m1_wmask,
    input  logic                  m1_rstrb,
    output logic [31:0]           m1_rdata,
    output logic                  m1_rbusy,
    output logic                  m1_wbusy,
    output logic [ADDR_WIDTH-1:0] s_addr,
    output logic [31:0]           s_wdata,
    output logic [3:0]            s_wmask,
    output logic                  s_rstrb,
    input  logic [31:0]           s_rdata,
    input  logic                  s_rbusy,
    input  logic                  s_wbusy,
    output logic [1:0]            dbg_state_o
);

    // Handshake: a master raises rstrb or a nonzero wmask for one cycle while its
    // busy outputs are low; busy stays high until the cycle after completion.
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

    state_t                state_q, state_d;
    logic                  last_q, owner_q, cur_w_q;
    logic [1:0]            pend_v_q, pend_w_q, rbusy_q, wbusy_q;
    logic [ADDR_WIDTH-1:0] pend_addr_q [2];
    logic [31:0]           pend_wdata_q [2];
    logic [3:0]            pend_wmask_q [2];
    logic [31:0]           rdata_q [2];
    logic [ADDR_WIDTH-1:0] s_addr_q;
    logic [31:0]           s_wdata_q;
    logic [3:0]            s_wmask_q;
    logic                  s_rstrb_q;

    logic [ADDR_WIDTH-1:0] in_addr [2];
    logic [31:0]           in_wdata [2];
    logic [3:0]            in_wmask [2];
    logic [1:0]            in_rstrb, in_wr, req, cand;
    logic                  done, issue, win, win_w;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic [31:0]           win_wdata;
    logic [3:0]            win_wmask;

    always_comb begin
        in_addr[0]  = m0_addr;  in_addr[1]  = m1_addr;
        in_wdata[0] = m0_wdata; in_wdata[1] = m1_wdata;
        in_wmask[0] = m0_wmask; in_wmask[1] = m1_wmask;
        in_rstrb    = {m1_rstrb, m0_rstrb};
        for (int i = 0; i < 2; i++) begin
            in_wr[i] = (in_wmask[i] != 4'd0);
            // Strobes from an already-busy master are protocol violations and dropped.
            req[i]   = (in_rstrb[i] | in_wr[i]) & ~(rbusy_q[i] | wbusy_q[i]);
        end
        cand  = pend_v_q | req;
        done  = (state_q == ST_WAIT) && !s_rbusy && !s_wbusy;
        issue = (cand != 2'b00) && ((state_q == ST_IDLE) || done);
        win   = (cand == 2'b11) ? ~last_q : cand[1];
        if (pend_v_q[win]) begin
            win_addr  = pend_addr_q[win];
            win_wdata = pend_wdata_q[win];
            win_wmask = pend_wmask_q[win];
            win_w     = pend_w_q[win];
        end else begin
            win_addr  = in_addr[win];
            win_wdata = in_wdata[win];
            win_wmask = in_wmask[win];
            win_w     = in_wr[win];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (issue) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (done) state_d = issue ? ST_ISSUE : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            cur_w_q   <= 1'b0;
            pend_v_q  <= 2'b00;
            pend_w_q  <= 2'b00;
            rbusy_q   <= 2'b00;
            wbusy_q   <= 2'b00;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            s_wmask_q <= '0;
            s_rstrb_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                pend_addr_q[i]  <= '0;
                pend_wdata_q[i] <= '0;
                pend_wmask_q[i] <= '0;
                rdata_q[i]      <= '0;
            end
        end else begin
            state_q <= state_d;
            if (issue) begin
                s_addr_q  <= win_addr;
                s_wdata_q <= win_wdata;
                s_wmask_q <= win_w ? win_wmask : 4'd0;
                s_rstrb_q <= !win_w;
                last_q    <= win;
                owner_q   <= win;
                cur_w_q   <= win_w;
            end else begin
                s_wmask_q <= 4'd0;
                s_rstrb_q <= 1'b0;
            end
            for (int i = 0; i < 2; i++) begin
                if (issue && (win == 1'(i))) begin
                    pend_v_q[i] <= 1'b0;
                end else if (req[i]) begin
                    pend_v_q[i]     <= 1'b1;
                    pend_w_q[i]     <= in_wr[i];
                    pend_addr_q[i]  <= in_addr[i];
                    pend_wdata_q[i] <= in_wdata[i];
                    pend_wmask_q[i] <= in_wmask[i];
                end
                if (req[i]) begin
                    rbusy_q[i] <= !in_wr[i];
                    wbusy_q[i] <= in_wr[i];
                end else if (done && (owner_q == 1'(i))) begin
                    rbusy_q[i] <= 1'b0;
                    wbusy_q[i] <= 1'b0;
                end
                if (done && (owner_q == 1'(i)) && !cur_w_q) rdata_q[i] <= s_rdata;
            end
        end
    end

    assign m0_rdata    = rdata_q[0];
    assign m1_rdata    = rdata_q[1];
    assign m0_rbusy    = rbusy_q[0];
    assign m1_rbusy    = rbusy_q[1];
    assign m0_wbusy    = wbusy_q[0];
    assign m1_wbusy    = wbusy_q[1];
    assign s_addr      = s_addr_q;
    assign s_wdata     = s_wdata_q;
    assign s_wmask     = s_wmask_q;
    assign s_rstrb     = s_rstrb_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_femtorv_mem_arbiter.sv
// Bench for femtorv_mem_arbiter: directed timing cases plus random two-master traffic
// against a reference memory, with a per-master expected-read-data queue.
module tb_femtorv_mem_arbiter;
  localparam int BOUND = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
  logic [3:0]  m0_wmask = '0, m1_wmask = '0;
  logic        m0_rstrb = 1'b0, m1_rstrb = 1'b0;
  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata, s_rdata;
  logic        m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy, s_rstrb, s_rbusy, s_wbusy;
  logic [3:0]  s_wmask;
  logic [1:0]  dbg_state;

  femtorv_mem_arbiter #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_rstrb(m0_rstrb),
    .m0_rdata(m0_rdata), .m0_rbusy(m0_rbusy), .m0_wbusy(m0_wbusy),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_rstrb(m1_rstrb),
    .m1_rdata(m1_rdata), .m1_rbusy(m1_rbusy), .m1_wbusy(m1_wbusy),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wmask(s_wmask), .s_rstrb(s_rstrb),
    .s_rdata(s_rdata), .s_rbusy(s_rbusy), .s_wbusy(s_wbusy),
    .dbg_state_o(dbg_state)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Slave model: word memory, busy for slv_lat cycles after each pulse.
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  int          slv_lat = 0;
  int          sl_cnt = 0;
  logic        sl_w = 1'b0;
  logic [7:0]  raddr = '0;
  int          pulses = 0;
  int          viol = 0;
  logic        prev_pulse = 1'b0;

  assign s_rdata = mem[raddr];
  assign s_rbusy = (sl_cnt != 0) && !sl_w;
  assign s_wbusy = (sl_cnt != 0) && sl_w;

  always @(posedge clk) begin
    if (s_rstrb || (s_wmask != 4'd0)) begin
      pulses <= pulses + 1;
      sl_cnt <= slv_lat;
      sl_w   <= (s_wmask != 4'd0);
      raddr  <= s_addr[9:2];
      for (int b = 0; b < 4; b++)
        if (s_wmask[b]) mem[s_addr[9:2]][8*b +: 8] = s_wdata[8*b +: 8];
    end else if (sl_cnt != 0) begin
      sl_cnt <= sl_cnt - 1;
    end
    if ((s_rstrb && (s_wmask != 4'd0)) || ((s_rstrb || (s_wmask != 4'd0)) && prev_pulse))
      viol <= viol + 1;
    prev_pulse <= s_rstrb || (s_wmask != 4'd0);
  end

  // Scoreboard
  logic [31:0] exp0_q[$];
  logic [31:0] exp1_q[$];
  logic [1:0]  prev_rb = '0, prev_b = '0;
  int          dur [2] = '{0, 0};
  int          issued = 0;
  logic [31:0] last_rd [2] = '{32'd0, 32'd0};

  task automatic mon(input int m);
    logic rb, b;
    logic [31:0] rd, e;
    rb = (m == 0) ? m0_rbusy : m1_rbusy;
    b  = rb | ((m == 0) ? m0_wbusy : m1_wbusy);
    rd = (m == 0) ? m0_rdata : m1_rdata;
    if (b) dur[m]++;
    if (prev_b[m] && !b) begin
      check_eq("busy_len_bound", 64'(dur[m] <= BOUND), 64'd1);
      dur[m] = 0;
    end
    if (prev_rb[m] && !rb) begin
      if (m == 0) begin
        check_eq("m0_rd_expected", 64'(exp0_q.size() > 0), 64'd1);
        if (exp0_q.size() > 0) begin e = exp0_q.pop_front(); check_eq("m0_rdata", 64'(rd), 64'(e)); end
      end else begin
        check_eq("m1_rd_expected", 64'(exp1_q.size() > 0), 64'd1);
        if (exp1_q.size() > 0) begin e = exp1_q.pop_front(); check_eq("m1_rdata", 64'(rd), 64'(e)); end
      end
    end
    prev_rb[m] = rb;
    prev_b[m]  = b;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      exp0_q.delete();
      exp1_q.delete();
      prev_rb = '0;
      prev_b  = '0;
      dur[0]  = 0;
      dur[1]  = 0;
    end else begin
      mon(0);
      mon(1);
    end
  end

  // Driver tasks
  task automatic drive_read(input int m, input logic [31:0] addr, input bit acc);
    if (m == 0) begin m0_rstrb = 1'b1; m0_addr = addr; end
    else        begin m1_rstrb = 1'b1; m1_addr = addr; end
    if (acc) begin
      issued++;
      last_rd[m] = ref_mem[addr[9:2]];
      if (m == 0) exp0_q.push_back(ref_mem[addr[9:2]]);
      else        exp1_q.push_back(ref_mem[addr[9:2]]);
    end
  endtask

  task automatic drive_write(input int m, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] mask, input bit also_rd);
    if (m == 0) begin m0_wmask = mask; m0_wdata = data; m0_addr = addr; m0_rstrb = also_rd; end
    else        begin m1_wmask = mask; m1_wdata = data; m1_addr = addr; m1_rstrb = also_rd; end
    issued++;
    for (int b = 0; b < 4; b++)
      if (mask[b]) ref_mem[addr[9:2]][8*b +: 8] = data[8*b +: 8];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    m0_rstrb = 1'b0; m1_rstrb = 1'b0;
    m0_wmask = 4'd0; m1_wmask = 4'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic rand_req(input int m);
    logic [7:0] w;
    logic [31:0] a;
    w = (m == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(16, 31));
    a = {22'd0, w, 2'b00};
    if ($urandom_range(0, 1) == 1) drive_read(m, a, 1'b1);
    else drive_write(m, a, $urandom, 4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)));
  endtask

  initial begin
    int n, p, ib, pb, k;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'h1000_0000 + 32'(i);
      ref_mem[i] = 32'h1000_0000 + 32'(i);
    end
    mem[64]     = 32'hDEADBEEF;
    ref_mem[64] = 32'hDEADBEEF;

    // Reset state
    do_reset();
    @(negedge clk);
    check_eq("rst_flags", 64'({m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy, s_rstrb, s_wmask}), 64'd0);
    check_eq("rst_s_addr", 64'(s_addr), 64'd0);
    check_eq("rst_rdata", {m0_rdata, m1_rdata}, 64'd0);

    // Single read, single-cycle slave
    slv_lat = 0;
    step();
    drive_read(0, 32'h100, 1'b1);
    step();
    @(negedge clk);
    check_eq("t1_pulse", 64'({s_rstrb, s_wmask}), 64'h10);
    check_eq("t1_s_addr", 64'(s_addr), 64'h100);
    check_eq("t1_rbusy_t1", 64'(m0_rbusy), 64'd1);
    step();
    @(negedge clk);
    check_eq("t1_rbusy_t2", 64'({m0_rbusy, s_rstrb}), 64'b10);
    step();
    @(negedge clk);
    check_eq("t1_rbusy_t3", 64'(m0_rbusy), 64'd0);
    check_eq("t1_rdata", 64'(m0_rdata), 64'hDEADBEEF);

    // Simultaneous reads after reset: m0 first, then m1
    do_reset();
    drive_read(0, 32'h10, 1'b1);
    drive_read(1, 32'h50, 1'b1);
    step();
    @(negedge clk);
    check_eq("t2_first_pulse", 64'({s_rstrb, s_addr}), {31'd0, 1'b1, 32'h10});
    check_eq("t2_m1_pending_busy", 64'(m1_rbusy), 64'd1);
    step();
    @(negedge clk);
    check_eq("t2_gap", 64'(s_rstrb), 64'd0);
    step();
    @(negedge clk);
    check_eq("t2_second_pulse", 64'({s_rstrb, s_addr}), {31'd0, 1'b1, 32'h50});
    repeat (3) step();
    drive_read(0, 32'h14, 1'b1);
    repeat (5) step();
    drive_read(0, 32'h18, 1'b1);
    drive_read(1, 32'h54, 1'b1);
    step();
    @(negedge clk);
    check_eq("t2_rr_first_m1", 64'({s_rstrb, s_addr}), {31'd0, 1'b1, 32'h54});
    step();
    step();
    @(negedge clk);
    check_eq("t2_rr_then_m0", 64'({s_rstrb, s_addr}), {31'd0, 1'b1, 32'h18});
    repeat (4) step();

    // m1 write with slave busy for 4 cycles
    slv_lat = 4;
    drive_write(1, 32'h80, 32'h0000ABCD, 4'b0011, 1'b0);
    p = pulses;
    step();
    @(negedge clk);
    check_eq("t3_wpulse", 64'({s_rstrb, s_wmask, s_wdata}), {27'd0, 1'b0, 4'b0011, 32'h0000ABCD});
    n = int'(m1_wbusy);
    repeat (11) begin
      step();
      @(negedge clk);
      n += int'(m1_wbusy);
    end
    check_eq("t3_wbusy_cycles", 64'(n), 64'd6);
    check_eq("t3_one_pulse", 64'(pulses - p), 64'd1);
    check_eq("t3_m1_rdata_kept", 64'(m1_rdata), 64'(last_rd[1]));

    // Strobe while busy is ignored
    slv_lat = 3;
    step();
    p = pulses;
    drive_read(0, 32'h20, 1'b1);
    step();
    step();
    drive_read(0, 32'h24, 1'b0);
    repeat (11) step();
    check_eq("t4_single_pulse", 64'(pulses - p), 64'd1);
    check_eq("t4_rdata_first", 64'(m0_rdata), 64'(last_rd[0]));
    check_eq("t4_idle_busy", 64'(m0_rbusy), 64'd0);

    // Asynchronous reset in WAIT with m1 pending
    slv_lat = 5;
    drive_read(0, 32'h28, 1'b1);
    step();
    drive_read(1, 32'h58, 1'b1);
    step();
    step();
    #2 reset = 1'b1;
    #1;
    check_eq("t5_async_busy", 64'({m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy, s_rstrb, s_wmask}), 64'd0);
    check_eq("t5_async_s_addr", 64'(s_addr), 64'd0);
    check_eq("t5_async_rdata", {m0_rdata, m1_rdata}, 64'd0);
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    p = pulses;
    repeat (10) step();
    check_eq("t5_pending_dropped", 64'(pulses - p), 64'd0);
    check_eq("t5_m1_idle", 64'(m1_rbusy), 64'd0);
    drive_read(1, 32'h5C, 1'b1);
    repeat (12) step();
    check_eq("t5_new_served", 64'(pulses - p), 64'd1);
    check_eq("t5_new_rdata", 64'(m1_rdata), 64'(last_rd[1]));

    // Random mixed traffic, disjoint address ranges per master
    ib = issued;
    pb = pulses;
    for (int c = 0; c < 10000; c++) begin
      slv_lat = $urandom_range(0, 3);
      if (!(m0_rbusy | m0_wbusy) && ($urandom_range(0, 2) == 0)) rand_req(0);
      if (!(m1_rbusy | m1_wbusy) && ($urandom_range(0, 2) == 0)) rand_req(1);
      step();
    end
    k = 0;
    while ((m0_rbusy | m0_wbusy | m1_rbusy | m1_wbusy) && (k < 200)) begin
      step();
      k++;
    end
    check_eq("drain_in_time", 64'(k < 200), 64'd1);
    repeat (2) step();
    check_eq("m0_reads_returned", 64'(exp0_q.size()), 64'd0);
    check_eq("m1_reads_returned", 64'(exp1_q.size()), 64'd0);
    check_eq("no_lost_or_dup", 64'(pulses - pb), 64'(issued - ib));
    check_eq("pulse_exclusive", 64'(viol), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
